// File: rtl/regfile_dumper_pkg.sv
// regfile_dumper_pkg
//   Shared definitions for the register file dumper: default word and
//   index widths, and the FSM state type.
package regfile_dumper_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// regfile_dumper_if
//   Bundles the register file read port and the output word stream.
//   master (the dumper) : drives rs, outValid, outData, outIndex;
//                         receives rdData, outReady.
//   slave  (env/consumer): the reverse.
//
// Handshake: a word moves when outValid && outReady at a rising clock
// edge. Once outValid rises, outData/outIndex stay stable until that
// edge; outValid does not depend on outReady, and outReady has no
// effect while outValid is low.
interface regfile_dumper_if
    import regfile_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] rs;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [ADDR_WIDTH-1:0] outIndex;

    modport master (
        output rs,
        input  rdData,
        output outValid,
        input  outReady,
        output outData,
        output outIndex
    );

    modport slave (
        input  rs,
        output rdData,
        input  outValid,
        output outReady,
        input  outData,
        input  outIndex
    );

endinterface

// File: rtl/regfile_dumper.sv
// regfile_dumper
//   Walks a register file from firstReg to lastReg (wrapping modulo
//   2^ADDR_WIDTH) and emits one (index, data) word per register on a
//   valid/ready stream.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   start              : request a dump (honoured only when idle)
//   firstReg, lastReg  : dump range, latched when start is accepted
//   bus (master)       : rs/rdData read port, outValid/outReady/
//                        outData/outIndex output stream
//   busy               : high whenever not idle
//   done               : one-cycle pulse after the final word is taken
//   dbg_state          : current FSM state
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] firstReg,
    input  logic [ADDR_WIDTH-1:0] lastReg,
    regfile_dumper_if.master      bus,
    output logic                  busy,
    output logic                  done,
    output state_t                dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_index_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  state_d = S_HOLD;
            S_HOLD:  if (bus.outReady) state_d = (index_q == last_q) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                index_q <= firstReg;
                last_q  <= lastReg;
            end
            // rdData is only ever sampled here, so it never reaches
            // outValid combinationally.
            if (state_q == S_READ) begin
                out_data_q  <= bus.rdData;
                out_index_q <= index_q;
            end
            // The increment wraps naturally at 2^ADDR_WIDTH.
            if (state_q == S_HOLD && bus.outReady && index_q != last_q)
                index_q <= index_q + IDX_ONE;
        end
    end

    // index_q only changes on entry to READ, so rs is stable through
    // READ/HOLD and keeps its last value while idle.
    assign bus.rs       = index_q;
    assign bus.outValid = (state_q == S_HOLD);
    assign bus.outData  = out_data_q;
    assign bus.outIndex = out_index_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_dumper.sv
module tb_regfile_dumper;
    import regfile_dumper_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] firstReg;
    logic [AW-1:0] lastReg;
    logic          busy;
    logic          done;
    state_t        dbg_state;

    logic [DW-1:0] regs [32];

    regfile_dumper_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .firstReg  (firstReg),
        .lastReg   (lastReg),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Register file model: combinational read.
    assign bus.rdData = regs[bus.rs];

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: expected {index, data} words in order
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge where the first word
    // should be visible (start edge + 2).
    task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        start    = 1'b1;
        firstReg = f;
        lastReg  = l;
        @(negedge clock);
        start = 1'b0;
        check("read_busy", busy, 1);
        check("read_valid", bus.outValid, 0);
        @(negedge clock);
        check("latency_valid", bus.outValid, 1);
    endtask

    // Consume words with outReady high, compare against exp_q, then
    // check the done pulse. With poke set, a conflicting start is
    // pulsed right after the first handshake.
    task automatic drain(input int n_exp, input bit poke, input int budget);
        int words;
        int last_hs;
        bit finished;
        logic [AW+DW-1:0] e;
        words    = 0;
        last_hs  = -100;
        finished = 1'b0;
        bus.outReady = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            start = 1'b0;
            if (done) begin
                check("done_gap", cyc - last_hs, 1);
                @(negedge clock);
                check("done_pulse_low", done, 0);
                check("idle_busy_low", busy, 0);
                finished = 1'b1;
                break;
            end
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {bus.outIndex, bus.outData}, 0);
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    check("word", {bus.outIndex, bus.outData}, e);
                end
                check("rs_in_hold", bus.rs, e[AW+DW-1:DW]);
                words++;
                last_hs = cyc;
                if (poke && words == 1) begin
                    start    = 1'b1;
                    firstReg = 5'd20;
                    lastReg  = 5'd25;
                end
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (!finished) check("timeout", 0, 1);
        check("word_count", words, n_exp);
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        bus.outReady = 1'b0;
    endtask

    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_i;
    int            vcount;
    bit            seen_done;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        firstReg     = '0;
        lastReg      = '0;
        bus.outReady = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = DW'(i * 3);
        regs[6] = 64'd20;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_valid", bus.outValid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rs", bus.rs, 0);
        check("rst_data", bus.outData, 0);
        check("rst_index", bus.outIndex, 0);
        check("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        @(negedge clock);

        // outReady while idle does nothing
        bus.outReady = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_ready_valid", bus.outValid, 0);
        check("idle_ready_busy", busy, 0);
        bus.outReady = 1'b0;

        // two-word dump 5..6
        exp_q.push_back({5'd5, 64'd15});
        exp_q.push_back({5'd6, 64'd20});
        bus.outReady = 1'b1;
        do_start(5'd5, 5'd6);
        drain(2, 1'b0, 40);

        // wrap-around 30..1
        exp_q.push_back({5'd30, 64'd90});
        exp_q.push_back({5'd31, 64'd93});
        exp_q.push_back({5'd0,  64'd0});
        exp_q.push_back({5'd1,  64'd3});
        bus.outReady = 1'b1;
        do_start(5'd30, 5'd1);
        drain(4, 1'b0, 60);

        // single word with back-pressure
        exp_q.push_back({5'd7, 64'd21});
        bus.outReady = 1'b0;
        do_start(5'd7, 5'd7);
        hold_d = 64'd21;
        hold_i = 5'd7;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", bus.outValid, 1);
            check("bp_data", bus.outData, hold_d);
            check("bp_index", bus.outIndex, hold_i);
            @(negedge clock);
        end
        drain(1, 1'b0, 20);

        // reset in HOLD of a 32-word dump
        bus.outReady = 1'b1;
        do_start(5'd10, 5'd9);
        vcount = 1;
        for (int c = 0; c < 40 && vcount < 3; c++) begin
            @(negedge clock);
            if (bus.outValid) vcount++;
        end
        check("abort_reached_hold", bus.outValid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_valid", bus.outValid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rs", bus.rs, 0);
        check("abort_data", bus.outData, 0);
        check("abort_index", bus.outIndex, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_quiet", seen_done, 0);
        bus.outReady = 1'b0;
        exp_q.push_back({5'd3, 64'd9});
        exp_q.push_back({5'd4, 64'd12});
        bus.outReady = 1'b1;
        do_start(5'd3, 5'd4);
        drain(2, 1'b0, 40);

        // start while busy is ignored
        exp_q.push_back({5'd12, 64'd36});
        exp_q.push_back({5'd13, 64'd39});
        bus.outReady = 1'b1;
        do_start(5'd12, 5'd13);
        drain(2, 1'b1, 40);
        repeat (3) @(negedge clock);
        check("poke_no_restart", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
